// File: rtl/interp_pkg.sv
// interp_pkg: shared types and constants for the halfband interpolation
// scheduler (FSM state encoding, clocks per sample, MAC phase indices).
package interp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Every sample period is exactly this many clk cycles.
    localparam int CLK_PER_SAM = 4;

    // First and last MAC phase within one sample period.
    localparam logic [1:0] PH_FIRST = 2'd0;
    localparam logic [1:0] PH_LAST  = 2'd3;

endpackage

// File: rtl/interp_strobe_gen.sv
// interp_strobe_gen: free-running phase/symbol counter plus the decodes that
// drive the time-shared polyphase MAC (enables, mac/ch/out selects, acc load).
// Build option: INTERP_SCHED_IQ_SHARE_EN makes ch_sel follow phase[1] so one
// multiplier serves I then Q; otherwise ch_sel is tied 0.
module interp_strobe_gen
    import interp_pkg::*;
#(
    parameter int SAM_PER_SYM = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic active_i,
    output logic sym_clk_en_o,
    output logic sam_clk_en_o,
    output logic mac_sel_o,
    output logic ch_sel_o,
    output logic acc_load_o,
    output logic out_sel_o,
    output logic sam_last_o,
    output logic cnt_wrap_o
);

    localparam int CNT_W = $clog2(CLK_PER_SAM * SAM_PER_SYM);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       phase;

    assign phase = cnt_q[1:0];

    // Counter advances while enabled and wraps naturally (power-of-two period);
    // it is cleared whenever the enable is low so every run starts at phase 0.
    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decode the registered count into strobes and selects; all zero when idle.
    always_comb begin
        sym_clk_en_o = 1'b0;
        sam_clk_en_o = 1'b0;
        mac_sel_o    = 1'b0;
        ch_sel_o     = 1'b0;
        acc_load_o   = 1'b0;
        out_sel_o    = 1'b0;
        sam_last_o   = 1'b0;
        cnt_wrap_o   = 1'b0;
        if (active_i) begin
            sym_clk_en_o = (cnt_q == '0);
            sam_clk_en_o = (phase == PH_FIRST);
            mac_sel_o    = phase[0];
            acc_load_o   = ~phase[0];
            out_sel_o    = phase[1];
`ifdef INTERP_SCHED_IQ_SHARE_EN
            ch_sel_o     = phase[1];
`else
            ch_sel_o     = 1'b0;
`endif
            sam_last_o   = (phase == PH_LAST);
            cnt_wrap_o   = (cnt_q == '1);
        end
    end

endmodule

// File: rtl/interp_sched.sv
// interp_sched: cycle scheduler for the halfband interpolator. Sequences
// IDLE -> PRIME (zero-fill delay line) -> RUN -> DRAIN (flush) -> IDLE and
// issues all filter strobes via interp_strobe_gen.
// Build option: INTERP_SCHED_IQ_SHARE_EN (I/Q multiplier sharing, see strobe gen).
module interp_sched
    import interp_pkg::*;
#(
    parameter int SAM_PER_SYM = 4,
    parameter int FLUSH_SAMS  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sym_clk_en,
    output logic sam_clk_en,
    output logic mac_sel,
    output logic ch_sel,
    output logic acc_load,
    output logic out_sel,
    output logic flush,
    output logic out_valid,
    output logic busy
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] flushCnt_q;
    logic [3:0] flushCnt_d;
    logic       samLast;
    logic       cntWrap;
    logic       cntEn;
    logic       active;

    assign active = (state_q != IDLE);
    assign cntEn  = (state_q != IDLE) && (state_d != IDLE);

    interp_strobe_gen #(
        .SAM_PER_SYM (SAM_PER_SYM)
    ) u_strobe (
        .clk          (clk),
        .reset        (reset),
        .en_i         (cntEn),
        .active_i     (active),
        .sym_clk_en_o (sym_clk_en),
        .sam_clk_en_o (sam_clk_en),
        .mac_sel_o    (mac_sel),
        .ch_sel_o     (ch_sel),
        .acc_load_o   (acc_load),
        .out_sel_o    (out_sel),
        .sam_last_o   (samLast),
        .cnt_wrap_o   (cntWrap)
    );

    // Next-state and status decode; prime/drain length counted in whole samples
    // so every state change lands on a sample boundary.
    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        flush      = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                busy       = 1'b0;
                flushCnt_d = '0;
                if (run) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                flush = 1'b1;
                if (samLast) begin
                    if (flushCnt_q == 4'(FLUSH_SAMS - 1)) begin
                        flushCnt_d = '0;
                        state_d    = RUN;
                    end else begin
                        flushCnt_d = flushCnt_q + 4'd1;
                    end
                end
            end
            RUN: begin
                out_valid = 1'b1;
                if (cntWrap && !run) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                flush     = 1'b1;
                out_valid = 1'b1;
                if (samLast) begin
                    if (flushCnt_q == 4'(FLUSH_SAMS - 1)) begin
                        flushCnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        flushCnt_d = flushCnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                flushCnt_d = '0;
            end
        endcase
    end

    // State and flush-counter registers; reset aborts immediately to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
        end
    end

endmodule

// File: tb/tb_interp_sched.sv
// tb_interp_sched: table-driven check of interp_sched (SAM_PER_SYM=4,
// FLUSH_SAMS=4) plus a hand-written period measurement.
module tb_interp_sched;

    logic clk;
    logic reset;
    logic run;
    logic sym_clk_en, sam_clk_en, mac_sel, ch_sel, acc_load, out_sel;
    logic flush, out_valid, busy;

    int compared;
    int mismatched;

    typedef struct {
        logic       rst;
        logic       run;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    interp_sched #(
        .SAM_PER_SYM (4),
        .FLUSH_SAMS  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .sym_clk_en (sym_clk_en),
        .sam_clk_en (sam_clk_en),
        .mac_sel    (mac_sel),
        .ch_sel     (ch_sel),
        .acc_load   (acc_load),
        .out_sel    (out_sel),
        .flush      (flush),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle for a busy cycle at count c:
    // {sym, sam, mac, ch, acc, out_sel, flush, out_valid, busy}
    function automatic logic [8:0] dec(int c, bit fl, bit vl);
        logic [3:0] cc;
        logic       ch;
        cc = 4'(c);
`ifdef INTERP_SCHED_IQ_SHARE_EN
        ch = cc[1];
`else
        ch = 1'b0;
`endif
        return {cc == 4'd0, cc[1:0] == 2'd0, cc[0], ch, ~cc[0], cc[1], fl, vl, 1'b1};
    endfunction

    function automatic logic [8:0] actual();
        return {sym_clk_en, sam_clk_en, mac_sel, ch_sel, acc_load, out_sel,
                flush, out_valid, busy};
    endfunction

    task automatic addVec(input logic r, input logic rn, input logic [8:0] e);
        vec_t v;
        v.rst = r;
        v.run = rn;
        v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive inputs, let one edge sample them, then settle away from the edge.
    task automatic applyStimulus(input logic r, input logic rn);
        reset = r;
        run   = rn;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] got,
                               input logic [8:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b expected %b (sym,sam,mac,ch,acc,osel,flush,valid,busy)",
                     name, got, exp);
        end
    endtask

    initial begin
        int lastSym;
        int lastSam;
        int symGap;
        int samGap;
        int seenSym;
        int seenSam;
        bit gotValid;

        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        run        = 1'b0;

        // Reset and idle.
        addVec(1, 0, 9'b0);
        addVec(0, 0, 9'b0);
        // run=1 held: prime 16 cycles, then one full RUN symbol.
        for (int c = 0; c < 16; c++) addVec(0, 1, dec(c, 1, 0));
        for (int c = 0; c < 16; c++) addVec(0, 1, dec(c, 0, 1));
        // Drop run mid-symbol: RUN finishes the symbol, then a 16-cycle drain.
        for (int c = 0; c < 16; c++) addVec(0, (c <= 6), dec(c, 0, 1));
        for (int c = 0; c < 16; c++) addVec(0, 0, dec(c, 1, 1));
        addVec(0, 0, 9'b0);
        addVec(0, 0, 9'b0);
        // Restart; run glitches low mid-symbol but is high at the wrap.
        for (int c = 0; c < 16; c++) addVec(0, 1, dec(c, 1, 0));
        for (int c = 0; c < 16; c++) addVec(0, !(c >= 3 && c <= 5), dec(c, 0, 1));
        // Next symbol: run low at the wrap, then high throughout the drain.
        for (int c = 0; c < 16; c++) addVec(0, (c < 10), dec(c, 0, 1));
        addVec(0, 0, dec(0, 1, 1));
        for (int c = 1; c < 16; c++) addVec(0, 1, dec(c, 1, 1));
        addVec(0, 1, 9'b0);
        for (int c = 0; c < 16; c++) addVec(0, 1, dec(c, 1, 0));
        // Reset at cnt=9 in RUN, then restart from a clean PRIME.
        for (int c = 0; c < 10; c++) addVec(0, 1, dec(c, 0, 1));
        addVec(1, 1, 9'b0);
        for (int c = 0; c < 3; c++) addVec(0, 1, dec(c, 1, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].run);
            checkOutput($sformatf("vec%0d", i), actual(), vecs[i].exp);
        end

        // Hand-written: keep running, wait (bounded) for out_valid, then
        // measure symbol and sample periods in steady RUN.
        gotValid = 1'b0;
        for (int k = 0; k < 100 && !gotValid; k++) begin
            applyStimulus(0, 1);
            gotValid = out_valid;
        end
        compared++;
        if (!gotValid) begin
            mismatched++;
            $display("[TB] FAIL valid_timeout: got out_valid=0 expected 1 within 100 cycles");
        end
        lastSym = -1;
        lastSam = -1;
        symGap  = 0;
        samGap  = 0;
        seenSym = 0;
        seenSam = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 1);
            if (sym_clk_en) begin
                if (lastSym >= 0) begin
                    symGap = k - lastSym;
                    seenSym++;
                end
                lastSym = k;
            end
            if (sam_clk_en) begin
                if (lastSam >= 0) begin
                    samGap = k - lastSam;
                    seenSam++;
                end
                lastSam = k;
            end
        end
        checkOutput("sym_period", 9'(symGap), 9'd16);
        checkOutput("sam_period", 9'(samGap), 9'd4);
        checkOutput("sam_count", 9'(seenSam), 9'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
